// File: rtl/keypad_entry_ctrl.sv
// Microwave keypad front end: debounces the one-hot digit keys, shifts digits into an
// M:ST:SO BCD entry buffer and offers the entry to the countdown datapath on start.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       clearn,
    input  logic       entry_en,
    input  logic       load_ready,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic       entry_valid,
    output logic       load_valid,
    output logic       key_err
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

    state_t        state_q, state_d;
    logic [9:0]    key_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          latch_q, latch_d;
    logic          startn_q;
    logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic          key_err_q, key_err_d;

    logic          stable, press_evt, start_evt, start_bad;
    logic [3:0]    key_digit;

    // Binary encode of the pressed key: bit gi of the digit is the OR of every key whose index has bit gi set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enc
            logic [9:0] mask;
            for (gj = 0; gj < 10; gj++) begin : g_bit
                if (((gj >> gi) & 1) == 1) begin : g_on
                    assign mask[gj] = keypad[gj];
                end else begin : g_off
                    assign mask[gj] = 1'b0;
                end
            end
            assign key_digit[gi] = |mask;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (keypad != key_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end

        stable    = (cnt_d == CNT_MAX);
        press_evt = stable && (keypad != '0) && !latch_q;
        start_evt = startn_q && !startn;
        start_bad = ({min_q, tens_q, ones_q} == 12'd0) || (tens_q > 4'd5);

        // The latch records any debounced press, even one that is discarded or erroneous.
        latch_d = latch_q;
        if (press_evt) begin
            latch_d = 1'b1;
        end else if (stable && (keypad == '0)) begin
            latch_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        key_err_d = 1'b0;

        if (!clearn) begin
            state_d = IDLE;
            min_d   = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (load_ready) begin
                        state_d = IDLE;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                    end
                end
                IDLE, ENTRY: begin
                    // A start in ENTRY takes the edge, so a coincident key accept is dropped.
                    if (entry_en) begin
                        if (start_evt && (state_q == ENTRY)) begin
                            if (start_bad) begin
                                key_err_d = 1'b1;
                            end else begin
                                state_d = LOAD;
                            end
                        end else if (press_evt) begin
                            if ($onehot(keypad)) begin
                                min_d   = tens_q;
                                tens_d  = ones_q;
                                ones_d  = key_digit;
                                state_d = ENTRY;
                            end else begin
                                key_err_d = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            key_q     <= '0;
            cnt_q     <= '0;
            latch_q   <= 1'b0;
            startn_q  <= 1'b1;
            min_q     <= 4'd0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= keypad;
            cnt_q     <= cnt_d;
            latch_q   <= latch_d;
            startn_q  <= startn;
            min_q     <= min_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            key_err_q <= key_err_d;
        end
    end

    assign min_bcd      = min_q;
    assign sec_tens_bcd = tens_q;
    assign sec_ones_bcd = ones_q;
    assign entry_valid  = (state_q != IDLE);
    assign load_valid   = (state_q == LOAD);
    assign key_err      = key_err_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Table-driven bench for keypad_entry_ctrl: per-cycle input/expected-output records,
// followed by a hand-written asynchronous reset during a pending load.
`timescale 1ms/1us
module tb_keypad_entry_ctrl;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] keypad = '0;
    logic       startn = 1'b1;
    logic       clearn = 1'b1;
    logic       entry_en = 1'b1;
    logic       load_ready = 1'b0;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic       entry_valid, load_valid, key_err;

    keypad_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .keypad       (keypad),
        .startn       (startn),
        .clearn       (clearn),
        .entry_en     (entry_en),
        .load_ready   (load_ready),
        .min_bcd      (min_bcd),
        .sec_tens_bcd (sec_tens_bcd),
        .sec_ones_bcd (sec_ones_bcd),
        .entry_valid  (entry_valid),
        .load_valid   (load_valid),
        .key_err      (key_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [9:0] key;
        logic       st, cl, en, rdy;
        logic [3:0] m, t, o;
        logic       ev, lv, er;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Expected-entry model advanced while the table is built.
    logic [3:0] em, et, eo;
    logic       eev, elv;

    task automatic addv(input int n, input logic [9:0] k, input logic st, input logic cl,
                        input logic en, input logic rdy, input logic er);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst = 1'b0; v.key = k; v.st = st; v.cl = cl; v.en = en; v.rdy = rdy;
            v.m = em; v.t = et; v.o = eo; v.ev = eev; v.lv = elv; v.er = er;
            vecs.push_back(v);
        end
    endtask

    task automatic model_clear();
        em = 4'd0; et = 4'd0; eo = 4'd0; eev = 1'b0; elv = 1'b0;
    endtask

    task automatic do_reset();
        vec_t v;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            v.rst = 1'b1; v.key = '0; v.st = 1'b1; v.cl = 1'b1; v.en = 1'b1; v.rdy = 1'b0;
            v.m = 4'd0; v.t = 4'd0; v.o = 4'd0; v.ev = 1'b0; v.lv = 1'b0; v.er = 1'b0;
            vecs.push_back(v);
        end
    endtask

    task automatic add_digit(input int d);
        logic [9:0] k;
        k = 10'd1 << d;
        addv(3, k, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        em = et; et = eo; eo = 4'(d); eev = 1'b1;
        addv(1, k, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addv(4, '0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [3:0] m, input logic [3:0] t,
                         input logic [3:0] o, input logic ev, input logic lv, input logic er);
        n_vec++;
        if (min_bcd !== m || sec_tens_bcd !== t || sec_ones_bcd !== o ||
            entry_valid !== ev || load_valid !== lv || key_err !== er) begin
            n_bad++;
            $display("FAIL %s: got %h:%h:%h ev=%b lv=%b err=%b, want %h:%h:%h ev=%b lv=%b err=%b",
                     name, min_bcd, sec_tens_bcd, sec_ones_bcd, entry_valid, load_valid, key_err,
                     m, t, o, ev, lv, er);
        end else begin
            $display("vec %s: %h:%h:%h ev=%b lv=%b err=%b ok",
                     name, min_bcd, sec_tens_bcd, sec_ones_bcd, entry_valid, load_valid, key_err);
        end
    endtask

    task automatic cyc(input logic [9:0] k, input logic st, input logic rdy);
        @(negedge clock);
        keypad = k; startn = st; clearn = 1'b1; entry_en = 1'b1; load_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want run completed");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1) single press, hold without repeat, release, second press
        do_reset();
        addv(3, 10'b0000000100, 1, 1, 1, 0, 0);
        eo = 4'd2; eev = 1'b1;
        addv(11, 10'b0000000100, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);
        addv(3, 10'b1000000000, 1, 1, 1, 0, 0);
        et = 4'd2; eo = 4'd9;
        addv(1, 10'b1000000000, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);

        // 2) three-sample glitch is never accepted
        do_reset();
        addv(3, 10'b0000010000, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);

        // 3) load handshake with a stalled datapath; keys ignored while loading
        do_reset();
        add_digit(1); add_digit(3); add_digit(0);
        elv = 1'b1;
        addv(1, '0, 0, 1, 1, 0, 0);
        addv(4, 10'b0100000000, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);
        model_clear();
        addv(1, '0, 1, 1, 1, 1, 0);
        addv(2, '0, 1, 1, 1, 1, 0);

        // 4) start refused for seconds-tens 7, then four more digits
        do_reset();
        add_digit(7); add_digit(5);
        addv(1, '0, 0, 1, 1, 0, 1);
        addv(1, '0, 0, 1, 1, 0, 0);
        addv(1, '0, 1, 1, 1, 0, 0);
        add_digit(1); add_digit(2); add_digit(3); add_digit(4);

        // 5) multi-hot code gives one error pulse; latch still clears on release
        do_reset();
        addv(3, 10'b0000000011, 1, 1, 1, 0, 0);
        addv(1, 10'b0000000011, 1, 1, 1, 0, 1);
        addv(3, 10'b0000000011, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);
        add_digit(5);

        // 6) clear aborts a load; entry_en=0 discards key and start
        do_reset();
        add_digit(1); add_digit(2);
        elv = 1'b1;
        addv(1, '0, 0, 1, 1, 0, 0);
        model_clear();
        addv(1, '0, 1, 0, 1, 0, 0);
        addv(1, '0, 1, 1, 1, 0, 0);
        add_digit(4);
        addv(4, 10'b0001000000, 1, 1, 0, 0, 0);
        addv(4, '0, 1, 1, 0, 0, 0);
        addv(1, '0, 0, 1, 0, 0, 0);
        addv(1, '0, 1, 1, 0, 0, 0);
        elv = 1'b1;
        addv(1, '0, 0, 1, 1, 0, 0);
        model_clear();
        addv(1, '0, 1, 1, 1, 1, 0);

        // 7) start with an all-zero entry is refused
        do_reset();
        add_digit(0);
        addv(1, '0, 0, 1, 1, 0, 1);
        addv(1, '0, 1, 1, 1, 0, 0);

        // 8) seconds-tens of 5 is accepted; ready already high transfers next edge
        do_reset();
        add_digit(5); add_digit(9);
        elv = 1'b1;
        addv(1, '0, 0, 1, 1, 1, 0);
        model_clear();
        addv(1, '0, 1, 1, 1, 1, 0);

        // 9) clear on the accept edge loses the key; held key does not retrigger
        do_reset();
        addv(3, 10'b0000001000, 1, 1, 1, 0, 0);
        addv(1, 10'b0000001000, 1, 0, 1, 0, 0);
        addv(2, 10'b0000001000, 1, 1, 1, 0, 0);
        addv(4, '0, 1, 1, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            resetn     = !vecs[i].rst;
            keypad     = vecs[i].key;
            startn     = vecs[i].st;
            clearn     = vecs[i].cl;
            entry_en   = vecs[i].en;
            load_ready = vecs[i].rdy;
            @(posedge clock);
            #1;
            check($sformatf("tbl%0d", i), vecs[i].m, vecs[i].t, vecs[i].o,
                  vecs[i].ev, vecs[i].lv, vecs[i].er);
        end

        // Asynchronous reset while a load is pending.
        for (int i = 0; i < 4; i++) cyc(10'b0000000010, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc('0, 1'b1, 1'b0);
        cyc('0, 1'b0, 1'b0);
        check("midop_load", 4'd0, 4'd0, 4'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        startn = 1'b1;
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        load_ready = 1'b1;
        @(posedge clock);
        #1;
        check("load_abandoned", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
